// File: rtl/ball_motion_ctrl.sv
// Tilt-driven ball motion: per-axis phase accumulators produce step requests, each
// single-pixel move is bounds-checked and then vetted by an external map lookup.
module ball_motion_ctrl #(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int POS_WIDTH        = 8,
    parameter int TILT_WIDTH       = 8,
    parameter int ACC_WIDTH        = 24,
    parameter int X_MAX            = 159,
    parameter int Y_MAX            = 119,
    parameter int X_START          = 0,
    parameter int Y_START          = 0,
    parameter int DEADZONE         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [TILT_WIDTH-1:0] tilt_x,
    input  logic signed [TILT_WIDTH-1:0] tilt_y,
    output logic                         map_req,
    output logic        [POS_WIDTH-1:0]  map_x,
    output logic        [POS_WIDTH-1:0]  map_y,
    input  logic                         map_ack,
    input  logic                         map_blocked,
    output logic        [POS_WIDTH-1:0]  x_pos,
    output logic        [POS_WIDTH-1:0]  y_pos,
    output logic                         pos_update,
    output logic                         bump_x,
    output logic                         bump_y
);

    // The magnitude must fit the accumulator; the clock rate only scales the step rate.
    if (ACC_WIDTH < TILT_WIDTH || CLK_FREQUENCY_HZ < 1) begin : g_bad_params
        $error("ball_motion_ctrl: ACC_WIDTH too small or CLK_FREQUENCY_HZ invalid");
    end

    localparam logic signed [TILT_WIDTH-1:0] TILT_MIN = {1'b1, {(TILT_WIDTH-1){1'b0}}};
    localparam logic        [TILT_WIDTH-1:0] TILT_SAT = {1'b0, {(TILT_WIDTH-1){1'b1}}};
    localparam logic        [TILT_WIDTH-1:0] DEAD     = TILT_WIDTH'(DEADZONE);
    localparam logic        [POS_WIDTH:0]    X_LIM    = (POS_WIDTH+1)'(X_MAX);
    localparam logic        [POS_WIDTH:0]    Y_LIM    = (POS_WIDTH+1)'(Y_MAX);
    localparam logic        [POS_WIDTH:0]    ONE      = (POS_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc_x, acc_y;
    logic [ACC_WIDTH:0]     sum_x, sum_y;
    logic                   pend_x, pend_y;
    logic                   dir_x, dir_y;
    logic                   sel_y;
    logic                   start, pick_y, cand_out;
    logic [POS_WIDTH:0]     base, cand;

    function automatic logic [TILT_WIDTH-1:0] tilt_mag(input logic signed [TILT_WIDTH-1:0] t);
        logic [TILT_WIDTH-1:0] m;
        if (t == TILT_MIN)
            m = TILT_SAT;
        else if (t[TILT_WIDTH-1])
            m = -t;
        else
            m = t;
        if (m <= DEAD)
            m = '0;
        return m;
    endfunction

    assign sum_x   = {1'b0, acc_x} + (ACC_WIDTH+1)'(tilt_mag(tilt_x));
    assign sum_y   = {1'b0, acc_y} + (ACC_WIDTH+1)'(tilt_mag(tilt_y));
    assign map_req = (state == CHECK);

    // Candidate is formed one bit wider so stepping below zero lands above the limit.
    always_comb begin
        start     = enable && (pend_x || pend_y);
        pick_y    = ~pend_x;
        base      = pick_y ? {1'b0, y_pos} : {1'b0, x_pos};
        cand      = (pick_y ? dir_y : dir_x) ? base - ONE : base + ONE;
        cand_out  = cand > (pick_y ? Y_LIM : X_LIM);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cand_out ? REJECT : CHECK;
            CHECK:   if (map_ack) state_nxt = map_blocked ? REJECT : COMMIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_x      <= '0;
            acc_y      <= '0;
            pend_x     <= 1'b0;
            pend_y     <= 1'b0;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            sel_y      <= 1'b0;
            map_x      <= '0;
            map_y      <= '0;
            x_pos      <= POS_WIDTH'(X_START);
            y_pos      <= POS_WIDTH'(Y_START);
            pos_update <= 1'b0;
            bump_x     <= 1'b0;
            bump_y     <= 1'b0;
        end else begin
            pos_update <= 1'b0;
            bump_x     <= 1'b0;
            bump_y     <= 1'b0;
            if (enable) begin
                acc_x <= sum_x[ACC_WIDTH-1:0];
                acc_y <= sum_y[ACC_WIDTH-1:0];
            end
            // A carry arriving while a move is already pending is dropped.
            if (enable && sum_x[ACC_WIDTH] && !pend_x) begin
                pend_x <= 1'b1;
                dir_x  <= tilt_x[TILT_WIDTH-1];
            end
            if (enable && sum_y[ACC_WIDTH] && !pend_y) begin
                pend_y <= 1'b1;
                dir_y  <= tilt_y[TILT_WIDTH-1];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_y <= pick_y;
                        if (!cand_out) begin
                            map_x <= pick_y ? x_pos : cand[POS_WIDTH-1:0];
                            map_y <= pick_y ? cand[POS_WIDTH-1:0] : y_pos;
                        end
                    end
                end
                COMMIT: begin
                    pos_update <= 1'b1;
                    if (sel_y) begin
                        y_pos  <= map_y;
                        pend_y <= 1'b0;
                    end else begin
                        x_pos  <= map_x;
                        pend_x <= 1'b0;
                    end
                end
                REJECT: begin
                    if (sel_y) begin
                        bump_y <= 1'b1;
                        pend_y <= 1'b0;
                    end else begin
                        bump_x <= 1'b1;
                        pend_x <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: table-driven tilt scenarios with a map responder feeding
// a scoreboard of expected commits/bumps, plus hand-written handshake and bound sequences.
module tb_ball_motion_ctrl;

    localparam int XS = 10;
    localparam int YS = 20;
    localparam int XM = 159;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic signed [7:0] tilt_x = '0;
    logic signed [7:0] tilt_y = '0;
    logic              map_req;
    logic        [7:0] map_x, map_y;
    logic              map_ack, map_blocked;
    logic        [7:0] x_pos, y_pos;
    logic              pos_update, bump_x, bump_y;

    logic ack_resp = 1'b0;
    logic ack_man  = 1'b0;
    logic cfg_blk  = 1'b0;
    logic resp_en  = 1'b1;
    int   cfg_lat  = 1;

    assign map_ack     = ack_resp | ack_man;
    assign map_blocked = cfg_blk;

    ball_motion_ctrl #(
        .CLK_FREQUENCY_HZ(100000000), .POS_WIDTH(8), .TILT_WIDTH(8), .ACC_WIDTH(8),
        .X_MAX(XM), .Y_MAX(119), .X_START(XS), .Y_START(YS), .DEADZONE(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tilt_x(tilt_x), .tilt_y(tilt_y),
        .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack),
        .map_blocked(map_blocked), .x_pos(x_pos), .y_pos(y_pos), .pos_update(pos_update),
        .bump_x(bump_x), .bump_y(bump_y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic is_bump;
        logic ax_y;
        int   x;
        int   y;
    } sb_t;

    sb_t sbq[$];
    int  mx, my;
    int  rcnt, req_cnt, upd_cnt, bump_cnt, ub_cnt, evt_n;
    int  cx, cy;
    bit  stable, req_prev;
    int  ev_x[4], ev_y[4], ev_u[4];

    // Map responder and output monitor share one sampling point on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            rcnt = 0; req_cnt = 0; upd_cnt = 0; bump_cnt = 0; ub_cnt = 0; evt_n = 0;
            ack_resp = 1'b0; req_prev = 1'b0; mx = XS; my = YS;
        end else begin
            if (map_req && !req_prev) begin
                req_cnt++;
                cx = int'(map_x); cy = int'(map_y); stable = 1'b1;
            end else if (map_req && (int'(map_x) != cx || int'(map_y) != cy)) begin
                stable = 1'b0;
            end
            req_prev = map_req;
            if (resp_en) begin
                if (ack_resp) begin
                    ack_resp = 1'b0;
                    chk("req_drop_after_ack", int'(map_req), 0);
                end else if (map_req) begin
                    rcnt++;
                    if (rcnt >= cfg_lat) begin
                        sb_t e;
                        ack_resp = 1'b1;
                        rcnt = 0;
                        chk("cand_stable", int'(stable), 1);
                        chk("cand_adjacent", int'((cx == mx && (cy == my + 1 || cy + 1 == my)) ||
                                                  (cy == my && (cx == mx + 1 || cx + 1 == mx))), 1);
                        e.is_bump = cfg_blk;
                        e.ax_y    = (cy != my);
                        e.x       = cfg_blk ? mx : cx;
                        e.y       = cfg_blk ? my : cy;
                        sbq.push_back(e);
                    end
                end
            end
            if (pos_update || bump_x || bump_y) begin
                if (evt_n < 4) begin
                    ev_x[evt_n] = int'(x_pos); ev_y[evt_n] = int'(y_pos); ev_u[evt_n] = int'(pos_update);
                end
                evt_n++;
                if (pos_update) upd_cnt++;
                if (bump_x || bump_y) bump_cnt++;
                if (sbq.size() > 0) begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_upd",  int'(pos_update), int'(!e.is_bump));
                    chk("sb_bx",   int'(bump_x), int'(e.is_bump && !e.ax_y));
                    chk("sb_by",   int'(bump_y), int'(e.is_bump && e.ax_y));
                    chk("sb_x",    int'(x_pos), e.x);
                    chk("sb_y",    int'(y_pos), e.y);
                    if (!e.is_bump) begin
                        mx = e.x; my = e.y;
                    end
                end else if (pos_update) begin
                    chk("sb_unexpected_update", 1, 0);
                end else begin
                    ub_cnt++;
                    chk("bound_hold_x", int'(x_pos), mx);
                    chk("bound_hold_y", int'(y_pos), my);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; resp_en = 1'b1; tilt_x = '0; tilt_y = '0; ack_man = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", int'(x_pos), XS);
        chk("rst_y", int'(y_pos), YS);
        chk("rst_req", int'(map_req), 0);
        chk("rst_mapx", int'(map_x), 0);
        chk("rst_mapy", int'(map_y), 0);
        chk("rst_pulses", int'({pos_update, bump_x, bump_y}), 0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic signed [7:0] tx, ty;
        int lat; logic blk; int cyc;
        int ex, ey, eupd, ebump, ereq;
    } vec_t;

    vec_t vt[9];

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int base_req, base_ub;
        //          tx    ty   lat blk cyc   ex  ey upd bump req
        vt[0] = '{  64,    0,  1, 0,   42,  20, 20, 10, 0, 10};
        vt[1] = '{   0,   64,  1, 0,   42,  10, 30, 10, 0, 10};
        vt[2] = '{   0,  -64,  1, 0,   42,  10, 10, 10, 0, 10};
        vt[3] = '{-128,    0,  1, 0,   42,   0, 20, 10, 0, 10};
        vt[4] = '{   4,   -4,  1, 0, 1000,  10, 20,  0, 0,  0};
        vt[5] = '{   5,    0,  1, 0,   60,  11, 20,  1, 0,  1};
        vt[6] = '{  64,    0,  5, 0,   42,  15, 20,  5, 0,  5};
        vt[7] = '{  64,    0,  5, 1,   42,  10, 20,  0, 5,  5};
        vt[8] = '{  64,    0,  1, 1,   42,  10, 20,  0, 10, 10};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            cfg_lat = vt[i].lat;
            cfg_blk = vt[i].blk;
            do_reset();
            tilt_x = vt[i].tx;
            tilt_y = vt[i].ty;
            repeat (vt[i].cyc) @(negedge clk);
            tilt_x = '0; tilt_y = '0;
            repeat (30) @(negedge clk);
            chk($sformatf("v%0d_x", i), int'(x_pos), vt[i].ex);
            chk($sformatf("v%0d_y", i), int'(y_pos), vt[i].ey);
            chk($sformatf("v%0d_upd", i), upd_cnt, vt[i].eupd);
            chk($sformatf("v%0d_bump", i), bump_cnt, vt[i].ebump);
            chk($sformatf("v%0d_req", i), req_cnt, vt[i].ereq);
            chk($sformatf("v%0d_sb_empty", i), sbq.size(), 0);
        end

        // Both axes pend together: X must be serviced first, then Y.
        cfg_lat = 1; cfg_blk = 1'b0;
        do_reset();
        tilt_x = 64; tilt_y = 64;
        k = 0;
        while (evt_n < 2 && k < 60) begin @(negedge clk); k++; end
        chk("simul_two_events", int'(evt_n >= 2), 1);
        chk("simul_first_x", ev_x[0], XS + 1);
        chk("simul_first_y", ev_y[0], YS);
        chk("simul_second_x", ev_x[1], XS + 1);
        chk("simul_second_y", ev_y[1], YS + 1);
        chk("simul_both_updates", ev_u[0] + ev_u[1], 2);
        tilt_x = '0; tilt_y = '0;
        repeat (30) @(negedge clk);
        chk("simul_sb_empty", sbq.size(), 0);

        // Low bound: once x reaches 0, further negative steps bump without a map request.
        do_reset();
        tilt_x = -128;
        k = 0;
        while (x_pos != 8'd0 && k < 200) begin @(negedge clk); k++; end
        chk("low_reached", int'(x_pos), 0);
        base_req = req_cnt; base_ub = ub_cnt;
        repeat (40) @(negedge clk);
        chk("low_no_req", req_cnt, base_req);
        chk("low_bumped", int'(ub_cnt > base_ub), 1);
        chk("low_hold", int'(x_pos), 0);
        tilt_x = '0;
        repeat (10) @(negedge clk);

        // High bound at X_MAX.
        do_reset();
        tilt_x = 127;
        k = 0;
        while (int'(x_pos) != XM && k < 2000) begin @(negedge clk); k++; end
        chk("high_reached", int'(x_pos), XM);
        base_req = req_cnt; base_ub = ub_cnt;
        repeat (40) @(negedge clk);
        chk("high_no_req", req_cnt, base_req);
        chk("high_bumped", int'(ub_cnt > base_ub), 1);
        chk("high_hold", int'(x_pos), XM);
        tilt_x = '0;
        repeat (10) @(negedge clk);

        // Disabling mid-lookup lets the in-flight move finish but starts nothing new.
        cfg_lat = 5; cfg_blk = 1'b0;
        do_reset();
        tilt_x = 64;
        k = 0;
        while (!map_req && k < 20) begin @(negedge clk); k++; end
        chk("en_req_seen", int'(map_req), 1);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("en_x_committed", int'(x_pos), XS + 1);
        chk("en_one_update", upd_cnt, 1);
        chk("en_one_req", req_cnt, 1);
        enable = 1'b1; tilt_x = '0;
        repeat (10) @(negedge clk);

        // Reset while a lookup is outstanding; a late ack must be ignored.
        cfg_lat = 1; cfg_blk = 1'b0;
        do_reset();
        resp_en = 1'b0;
        tilt_x = 64;
        k = 0;
        while (!map_req && k < 20) begin @(negedge clk); k++; end
        chk("rst_mid_req", int'(map_req), 1);
        chk("rst_mid_candx", int'(map_x), XS + 1);
        chk("rst_mid_candy", int'(map_y), YS);
        tilt_x = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_drop", int'(map_req), 0);
        chk("rst_mid_x", int'(x_pos), XS);
        reset = 1'b0;
        ack_man = 1'b1;
        repeat (2) @(negedge clk);
        ack_man = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_ack_x", int'(x_pos), XS);
        chk("late_ack_y", int'(y_pos), YS);
        chk("late_ack_events", evt_n, 0);
        chk("late_ack_no_req", req_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
